// File: rtl/axil_mmr_initiator.sv
// rtl/axil_mmr_initiator.sv - single-outstanding AXI4-Lite master for MMR register commands
// Optional error counter enabled by AXIL_MMR_INITIATOR_ERRCNT_EN.
module axil_mmr_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_is_write,
`ifdef AXIL_MMR_INITIATOR_ERRCNT_EN
    output logic [15:0]             err_count,
    input  logic                    err_clear,
`endif
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic                    write_q;
    logic                    aw_done;
    logic                    w_done;
    logic                    rst_done;
    logic                    cmd_hs;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    r_hs;

    // Handshakes derived from state so no ready-to-valid path exists.
    assign cmd_hs = (state == IDLE) && rst_done && cmd_valid;
    assign aw_hs  = (state == WR) && !aw_done && m_axil_awready;
    assign w_hs   = (state == WR) && !w_done && m_axil_wready;
    assign b_hs   = (state == WR_B) && m_axil_bvalid;
    assign r_hs   = (state == RD_R) && m_axil_rvalid;

    always_comb begin
        state_next     = state;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        m_axil_awaddr  = addr_q;
        m_axil_araddr  = addr_q;
        m_axil_wdata   = wdata_q;
        m_axil_wstrb   = wstrb_q;
        case (state)
            IDLE: begin
                // rst_done keeps cmd_ready low in the first cycle out of reset
                cmd_ready = rst_done;
                if (cmd_hs) begin
                    state_next = cmd_write ? WR : RD_AR;
                end
            end
            WR: begin
                m_axil_awvalid = !aw_done;
                m_axil_wvalid  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_next = WR_B;
                end
            end
            WR_B: begin
                m_axil_bready = 1'b1;
                if (b_hs) state_next = RSP;
            end
            RD_AR: begin
                m_axil_arvalid = 1'b1;
                if (m_axil_arready) state_next = RD_R;
            end
            RD_R: begin
                m_axil_rready = 1'b1;
                if (r_hs) state_next = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            write_q      <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            rst_done     <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= 2'b00;
            rsp_is_write <= 1'b0;
        end else begin
            state    <= state_next;
            rst_done <= 1'b1;
            if (cmd_hs) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                write_q <= cmd_write;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (b_hs) begin
                rsp_rdata    <= '0;
                rsp_resp     <= m_axil_bresp;
                rsp_is_write <= write_q;
            end
            if (r_hs) begin
                rsp_rdata    <= m_axil_rdata;
                rsp_resp     <= m_axil_rresp;
                rsp_is_write <= write_q;
            end
        end
    end

`ifdef AXIL_MMR_INITIATOR_ERRCNT_EN
    logic err_event;
    assign err_event = (b_hs && (m_axil_bresp != 2'b00)) || (r_hs && (m_axil_rresp != 2'b00));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            err_count <= 16'h0000;
        end else if (err_clear) begin
            err_count <= 16'h0000;
        end else if (err_event && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_axil_mmr_initiator.sv
// tb/tb_axil_mmr_initiator.sv - table-driven bench for axil_mmr_initiator
// Exercises err_count sequences when AXIL_MMR_INITIATOR_ERRCNT_EN is defined.
module tb_axil_mmr_initiator;
    logic        clock = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_is_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [15:0] err_count;
    logic        err_clear;
    logic        clr_on_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    axil_mmr_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_is_write(rsp_is_write),
`ifdef AXIL_MMR_INITIATOR_ERRCNT_EN
        .err_count(err_count), .err_clear(err_clear),
`endif
        .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

`ifndef AXIL_MMR_INITIATOR_ERRCNT_EN
    assign err_count = 16'h0000;
`endif

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [31:0] rd;
        logic [1:0]  resp;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          rb_dly;
        int          hold;
        int          exp_lat;
        int          exp_av;
        int          exp_wv;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic slave_idle;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        err_clear = 0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int lat, aw_hi, w_hi, ar_hi, aw_hs, w_hs, ar_hs, b_hs, r_hs, bw, rw, viol, hviol;
        logic [31:0] seen_a, seen_d, cap_d;
        logic [3:0]  seen_s;
        logic [1:0]  cap_r;
        logic        cap_w;
        bit          done;
        lat = 0; aw_hi = 0; w_hi = 0; ar_hi = 0; aw_hs = 0; w_hs = 0; ar_hs = 0;
        b_hs = 0; r_hs = 0; bw = 0; rw = 0; viol = 0; hviol = 0; done = 0;
        seen_a = 0; seen_d = 0; seen_s = 0;
        cmd_valid = 1; cmd_write = v.w; cmd_addr = v.addr; cmd_wdata = v.wd; cmd_wstrb = v.strb;
        bresp = v.resp; rresp = v.resp; rdata = v.rd;
        chk($sformatf("%s.cmd_ready", tag), 32'(cmd_ready), 32'd1);
        tick;
        cmd_valid = 0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        while (!done && lat < 60) begin
            lat++;
            if (rsp_valid) begin
                done = 1;
            end else begin
                if (cmd_ready) viol++;
                if (aw_hs > 0 && w_hs > 0 && b_hs == 0) bw++;
                bvalid = (bw > v.rb_dly) && (b_hs == 0);
                if (bready && !(aw_hs > 0 && w_hs > 0)) viol++;
                err_clear = clr_on_b && bvalid && bready;
                if (bvalid && bready) b_hs++;
                if (ar_hs > 0 && r_hs == 0) rw++;
                rvalid = (rw > v.rb_dly) && (r_hs == 0);
                if (rready && ar_hs == 0) viol++;
                if (rvalid && rready) r_hs++;
                awready = 0;
                if (awvalid) begin
                    aw_hi++;
                    if (aw_hi == 1) seen_a = awaddr; else if (awaddr !== seen_a) viol++;
                    awready = aw_hi > v.aw_dly;
                    if (awready) aw_hs++;
                end
                wready = 0;
                if (wvalid) begin
                    w_hi++;
                    if (w_hi == 1) begin seen_d = wdata; seen_s = wstrb; end
                    else if (wdata !== seen_d || wstrb !== seen_s) viol++;
                    wready = w_hi > v.w_dly;
                    if (wready) w_hs++;
                end
                arready = 0;
                if (arvalid) begin
                    ar_hi++;
                    if (ar_hi == 1) seen_a = araddr; else if (araddr !== seen_a) viol++;
                    arready = ar_hi > v.ar_dly;
                    if (arready) ar_hs++;
                end
                tick;
            end
        end
        slave_idle;
        chk($sformatf("%s.latency", tag), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("%s.rsp_rdata", tag), rsp_rdata, v.exp_rdata);
        chk($sformatf("%s.rsp_resp", tag), 32'(rsp_resp), 32'(v.resp));
        chk($sformatf("%s.rsp_is_write", tag), 32'(rsp_is_write), 32'(v.w));
        chk($sformatf("%s.addr_seen", tag), seen_a, v.addr);
        chk($sformatf("%s.wdata_seen", tag), seen_d, v.w ? v.wd : 32'h0);
        chk($sformatf("%s.wstrb_seen", tag), 32'(seen_s), v.w ? 32'(v.strb) : 32'h0);
        chk($sformatf("%s.addr_valid_cycles", tag), 32'(v.w ? aw_hi : ar_hi), 32'(v.exp_av));
        chk($sformatf("%s.wvalid_cycles", tag), 32'(w_hi), 32'(v.exp_wv));
        chk($sformatf("%s.handshakes", tag),
            {8'(aw_hs), 8'(w_hs), 8'(ar_hs), 4'(b_hs), 4'(r_hs)},
            v.w ? 32'h0101_0010 : 32'h0000_0101);
        chk($sformatf("%s.protocol", tag), 32'(viol), 32'd0);
        cap_d = rsp_rdata; cap_r = rsp_resp; cap_w = rsp_is_write;
        rsp_ready = 0;
        for (int i = 0; i < v.hold; i++) begin
            tick;
            if (!rsp_valid || cmd_ready || rsp_rdata !== cap_d || rsp_resp !== cap_r ||
                rsp_is_write !== cap_w) hviol++;
        end
        chk($sformatf("%s.hold_stable", tag), 32'(hviol), 32'd0);
        rsp_ready = 1;
        tick;
        rsp_ready = 0;
        chk($sformatf("%s.ready_after_rsp", tag), {30'd0, cmd_ready, rsp_valid}, 32'h2);
    endtask

    task automatic check_all_zero(input string tag);
        chk($sformatf("%s.ctl", tag),
            {25'd0, cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
        chk($sformatf("%s.awaddr", tag), awaddr, 32'h0);
        chk($sformatf("%s.araddr", tag), araddr, 32'h0);
        chk($sformatf("%s.wdata", tag), wdata, 32'h0);
        chk($sformatf("%s.rsp", tag), {25'd0, wstrb, rsp_resp, rsp_is_write}, 32'h0);
        chk($sformatf("%s.rsp_rdata", tag), rsp_rdata, 32'h0);
    endtask

    task automatic do_reset;
        resetn = 0;
        tick;
        tick;
        resetn = 1;
        tick;
    endtask

    initial begin
        vec_t ev;
        resetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; bresp = 0; rresp = 0; rdata = 0; clr_on_b = 0;
        slave_idle;

        //          w  addr           wdata          strb  rdata          resp  aw w ar rb hold lat av wv exp_rdata
        vecs[0] = '{1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00, 0, 0, 0, 1, 0,  4, 1, 1, 32'h0};
        vecs[1] = '{1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3, 32'h0,         2'b00, 3, 0, 0, 1, 0,  7, 4, 1, 32'h0};
        vecs[2] = '{1, 32'h0000_0024, 32'h0102_0304, 4'h8, 32'h0,         2'b10, 0, 2, 0, 1, 0,  6, 1, 3, 32'h0};
        vecs[3] = '{0, 32'h0000_0004, 32'h0,         4'h0, 32'h1234_5678, 2'b00, 0, 0, 0, 5, 0,  8, 1, 0, 32'h1234_5678};
        vecs[4] = '{0, 32'h0000_0008, 32'h0,         4'h0, 32'hA5A5_5A5A, 2'b10, 0, 0, 2, 1, 10, 6, 3, 0, 32'hA5A5_5A5A};
        vecs[5] = '{0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'hFFFF_FFFF, 2'b11, 0, 0, 0, 0, 0,  3, 1, 0, 32'hFFFF_FFFF};
        vecs[6] = '{1, 32'h0000_0030, 32'h55AA_55AA, 4'h5, 32'h0,         2'b01, 2, 2, 0, 0, 0,  5, 3, 3, 32'h0};

        @(negedge clock);
        tick;
        check_all_zero("reset");
        chk("reset.err_count", 32'(err_count), 32'h0);
        resetn = 1;
        tick;
        chk("idle.cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while waiting in WR_B with bvalid low
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h7777_8888; cmd_wstrb = 4'hF;
        tick;
        cmd_valid = 0;
        awready = 1; wready = 1;
        tick;
        slave_idle;
        chk("midrst.in_wr_b", {30'd0, bready, awvalid}, 32'h2);
        resetn = 0;
        tick;
        check_all_zero("midrst");
        resetn = 1;
        tick;
        chk("midrst.cmd_ready_after", 32'(cmd_ready), 32'd1);

`ifdef AXIL_MMR_INITIATOR_ERRCNT_EN
        do_reset;
        ev = vecs[4];
        run_txn(ev, "err_rd");
        chk("err_rd.err_count", 32'(err_count), 32'd1);
        do_reset;
        ev = '{1, 32'h0000_0050, 32'h1111_2222, 4'hF, 32'h0, 2'b10, 0, 0, 0, 1, 0, 4, 1, 1, 32'h0};
        for (int k = 1; k <= 3; k++) begin
            run_txn(ev, $sformatf("err_wr%0d", k));
            chk($sformatf("err_wr%0d.err_count", k), 32'(err_count), 32'(k));
        end
        clr_on_b = 1;
        run_txn(ev, "err_clr");
        clr_on_b = 0;
        chk("err_clr.err_count", 32'(err_count), 32'd0);
`else
        do_reset;
        ev = vecs[0];
        run_txn(ev, "post_reset");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
